// File: rtl/zeroheti_dmem_arbiter.sv
// zeroheti_dmem_arbiter: one-grant-per-cycle OBI arbiter and window check in front of the single-port DMEM SRAM.
// Define ZEROHETI_DMEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module zeroheti_dmem_arbiter #(
    parameter int unsigned NumReq = 2,
    parameter logic [31:0] BaseAddr = 32'h0002_0000,
    parameter int unsigned MemWords = 1024,
    localparam int unsigned AW = $clog2(MemWords)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumReq-1:0]   req_i,
    input  logic [NumReq-1:0]   we_i,
    input  logic [NumReq*4-1:0] be_i,
    input  logic [NumReq*32-1:0] addr_i,
    input  logic [NumReq*32-1:0] wdata_i,
    output logic [NumReq-1:0]   gnt_o,
    output logic [NumReq-1:0]   rvalid_o,
    output logic [NumReq*32-1:0] rdata_o,
    output logic [NumReq-1:0]   err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [3:0]          mem_be_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [31:0]         mem_wdata_o,
    input  logic [31:0]         mem_rdata_i
);
    localparam int unsigned IW = NumReq > 1 ? $clog2(NumReq) : 1;
    // 33-bit window top so a window ending at 4 GiB cannot wrap to zero
    localparam logic [32:0] TopAddr = {1'b0, BaseAddr} + (33'(MemWords) << 2);

    logic [IW-1:0] win, rsp_idx_q;
    logic found, hit, rsp_valid_q, rsp_we_q, rsp_err_q;
    logic [31:0] sel_addr;

`ifdef ZEROHETI_DMEM_ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int k = int'(NumReq) - 1; k >= 0; k--)
            if (req_i[k]) begin
                win = IW'(k);
                found = 1'b1;
            end
    end
`else
    logic [IW-1:0] last_q, cand;

    always_comb begin
        win = '0;
        found = 1'b0;
        cand = '0;
        for (int k = 1; k <= int'(NumReq); k++) begin
            cand = IW'((int'(last_q) + k) % int'(NumReq));
            if (!found && req_i[cand]) begin
                win = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) last_q <= IW'(NumReq - 1);
        else if (found) last_q <= win;
`endif

    assign sel_addr = addr_i[32*win +: 32];
    assign hit = {1'b0, sel_addr} >= {1'b0, BaseAddr} && {1'b0, sel_addr} < TopAddr && sel_addr[1:0] == 2'b00;

    assign gnt_o = found ? NumReq'(1) << win : '0;
    assign mem_req_o = found && hit;
    assign mem_we_o = mem_req_o && we_i[win];
    assign mem_be_o = mem_req_o ? be_i[4*win +: 4] : '0;
    assign mem_addr_o = mem_req_o ? AW'((sel_addr - BaseAddr) >> 2) : '0;
    assign mem_wdata_o = mem_req_o ? wdata_i[32*win +: 32] : '0;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_idx_q <= '0;
            rsp_we_q <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_valid_q <= found;
            rsp_idx_q <= win;
            rsp_we_q <= we_i[win];
            rsp_err_q <= !hit;
        end

    assign rvalid_o = rsp_valid_q ? NumReq'(1) << rsp_idx_q : '0;
    assign err_o = rsp_valid_q && rsp_err_q ? NumReq'(1) << rsp_idx_q : '0;

    for (genvar g = 0; g < NumReq; g++) begin : g_rdata
        assign rdata_o[32*g +: 32] = rsp_valid_q && rsp_idx_q == IW'(g) && !rsp_we_q && !rsp_err_q ? mem_rdata_i : '0;
    end
endmodule

// File: tb/tb_zeroheti_dmem_arbiter.sv
// tb_zeroheti_dmem_arbiter: vector table plus response scoreboard against a behavioural SRAM.
module tb_zeroheti_dmem_arbiter;
`ifdef ZEROHETI_DMEM_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic clk_i = 1'b0, rst_i = 1'b1;
    logic [1:0] req_i = '0, we_i = '0, gnt_o, rvalid_o, err_o;
    logic [7:0] be_i = '0;
    logic [63:0] addr_i = '0, wdata_i = '0, rdata_o;
    logic mem_req_o, mem_we_o;
    logic [3:0] mem_be_o;
    logic [9:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i = '0;

    zeroheti_dmem_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] sram [1024];
    logic [31:0] shadow [1024];

    always @(posedge clk_i)
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else mem_rdata_i <= sram[mem_addr_o];
        end

    typedef struct {
        logic [1:0] req, we;
        logic [7:0] be;
        logic [63:0] addr, wdata;
        logic [1:0] gnt;
        string name;
    } vec_t;

    typedef struct {
        bit v;
        int idx;
        bit err;
        logic [31:0] rdata;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb[$];
    int checks = 0, errors = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return a >= 32'h0002_0000 && a < 32'h0002_1000 && a[1:0] == 2'b00;
    endfunction

    task automatic check_rsp(input string n);
        rsp_t e;
        logic [1:0] ev;
        if (sb.size() == 0) begin
            chk({n, "/sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        ev = e.v ? 2'(1 << e.idx) : 2'b00;
        chk({n, "/rvalid"}, 64'(rvalid_o), 64'(ev));
        chk({n, "/err"}, 64'(err_o), e.err ? 64'(ev) : 64'd0);
        chk({n, "/rdata"}, rdata_o, e.v ? 64'(e.rdata) << (32 * e.idx) : 64'd0);
    endtask

    task automatic check_req(input vec_t v);
        int w, wi;
        logic [31:0] a, rd;
        bit h;
        chk({v.name, "/gnt"}, 64'(gnt_o), 64'(v.gnt));
        if (v.gnt == 2'b00) begin
            chk({v.name, "/mem_req"}, 64'(mem_req_o), 64'd0);
            sb.push_back('{1'b0, 0, 1'b0, 32'h0});
            return;
        end
        w = v.gnt[1] ? 1 : 0;
        a = v.addr[32*w +: 32];
        h = in_win(a);
        rd = 32'h0;
        chk({v.name, "/mem_req"}, 64'(mem_req_o), 64'(h));
        if (h) begin
            wi = int'((a - 32'h0002_0000) >> 2);
            chk({v.name, "/mem_addr"}, 64'(mem_addr_o), 64'(wi));
            chk({v.name, "/mem_we"}, 64'(mem_we_o), 64'(v.we[w]));
            chk({v.name, "/mem_be"}, 64'(mem_be_o), 64'(v.be[4*w +: 4]));
            chk({v.name, "/mem_wdata"}, 64'(mem_wdata_o), 64'(v.wdata[32*w +: 32]));
            if (v.we[w]) begin
                for (int b = 0; b < 4; b++)
                    if (v.be[4*w+b]) shadow[wi][8*b +: 8] = v.wdata[32*w+8*b +: 8];
            end else rd = shadow[wi];
        end
        sb.push_back('{1'b1, w, !h, rd});
    endtask

    task automatic step(input vec_t v);
        req_i = v.req;
        we_i = v.we;
        be_i = v.be;
        addr_i = v.addr;
        wdata_i = v.wdata;
        @(negedge clk_i);
        check_rsp(v.name);
        check_req(v);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 1024; i++) begin
            sram[i] = '0;
            shadow[i] = '0;
        end
        vecs.push_back('{2'b01, 2'b01, 8'h0F, {32'h0, 32'h0002_0010}, {32'h0, 32'hDEADBEEF}, 2'b01, "wr_m0"});
        vecs.push_back('{2'b01, 2'b00, 8'h0F, {32'h0, 32'h0002_0010}, 64'h0, 2'b01, "rd_m0"});
        vecs.push_back('{2'b10, 2'b10, 8'hF0, {32'h0002_0020, 32'h0}, {32'h1122_3344, 32'h0}, 2'b10, "wr_m1"});
        for (int i = 0; i < 6; i++)
            vecs.push_back('{2'b11, 2'b00, 8'hFF, {32'h0002_0020, 32'h0002_0010}, 64'h0,
                             FP ? 2'b01 : (i % 2 == 1 ? 2'b10 : 2'b01), $sformatf("both%0d", i)});
        vecs.push_back('{2'b10, 2'b00, 8'hF0, {32'h0001_0000, 32'h0}, 64'h0, 2'b10, "below"});
        vecs.push_back('{2'b10, 2'b00, 8'hF0, {32'h0002_1000, 32'h0}, 64'h0, 2'b10, "top"});
        vecs.push_back('{2'b01, 2'b00, 8'h0F, {32'h0, 32'h0002_0002}, 64'h0, 2'b01, "misalign"});
        vecs.push_back('{2'b01, 2'b01, 8'h0F, {32'h0, 32'h0002_1000}, {32'h0, 32'hBAD0BAD0}, 2'b01, "wr_err"});
        vecs.push_back('{2'b10, 2'b10, 8'hF0, {32'h0002_0FFC, 32'h0}, {32'hCAFE_F00D, 32'h0}, 2'b10, "wr_last"});
        vecs.push_back('{2'b01, 2'b00, 8'h0F, {32'h0, 32'h0002_0FFC}, 64'h0, 2'b01, "rd_last"});
        vecs.push_back('{2'b10, 2'b10, 8'h20, {32'h0002_0020, 32'h0}, {32'h0000_AB00, 32'h0}, 2'b10, "byte_wr"});
        vecs.push_back('{2'b10, 2'b00, 8'hF0, {32'h0002_0020, 32'h0}, 64'h0, 2'b10, "byte_rd"});
        vecs.push_back('{2'b00, 2'b00, 8'h00, 64'h0, 64'h0, 2'b00, "idle"});

        @(negedge clk_i);
        chk("rst/gnt", 64'(gnt_o), 64'd0);
        chk("rst/rvalid", 64'(rvalid_o), 64'd0);
        chk("rst/err", 64'(err_o), 64'd0);
        chk("rst/rdata", rdata_o, 64'd0);
        chk("rst/mem", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 64'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        sb.push_back('{1'b0, 0, 1'b0, 32'h0});

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
        chk("byte_merge", 64'(shadow[8]), 64'h1122_AB44);

        // A granted read whose response edge is swallowed by reset
        step('{2'b01, 2'b00, 8'h0F, {32'h0, 32'h0002_0010}, 64'h0, 2'b01, "pre_rst"});
        req_i = 2'b01;
        we_i = 2'b00;
        addr_i = {32'h0, 32'h0002_0014};
        @(negedge clk_i);
        check_rsp("pre_rst");
        chk("mid_rst/gnt", 64'(gnt_o), 64'd1);
        #1 rst_i = 1'b1;
        req_i = 2'b00;
        @(posedge clk_i);
        #1 chk("mid_rst/rvalid", 64'(rvalid_o), 64'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        sb.delete();
        sb.push_back('{1'b0, 0, 1'b0, 32'h0});
        v = '{2'b11, 2'b00, 8'hFF, {32'h0002_0020, 32'h0002_0010}, 64'h0, 2'b01, "post_rst"};
        step(v);
        step('{2'b00, 2'b00, 8'h00, 64'h0, 64'h0, 2'b00, "idle_end"});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
